// File: rtl/rsqrt_pkg.sv
// rtl/rsqrt_pkg.sv - shared types and constants for the rsqrt operand front-end
package rsqrt_pkg;

    typedef enum logic [2:0] {
        CLS_NORMAL  = 3'd0,
        CLS_SUBNORM = 3'd1,
        CLS_ZERO    = 3'd2,
        CLS_INF     = 3'd3,
        CLS_NEG     = 3'd4,
        CLS_NAN     = 3'd5
    } rsqrt_class_e;

    localparam logic [63:0] RSQRT_QNAN         = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] RSQRT_ONE          = 64'h3FF0_0000_0000_0000;
    localparam int          RSQRT_SUB_PRESCALE = 54;
    localparam int          RSQRT_POST_SCALE   = 27;

    typedef struct packed {
        logic [63:0]  x_bits;
        rsqrt_class_e cls;
        logic [63:0]  bypass;
        logic         scale;
    } rsqrt_entry_t;

endpackage

// File: rtl/rsqrt_classify.sv
// rtl/rsqrt_classify.sv - combinational binary64 classifier and subnormal pre-scaler
module rsqrt_classify
    import rsqrt_pkg::*;
(
    input  logic [63:0]  in_bits,
    output logic [63:0]  x_bits,
    output rsqrt_class_e cls,
    output logic [63:0]  bypass,
    output logic         scale
);

    logic        sgn;
    logic [10:0] exp_f;
    logic [51:0] frac;
    logic        exp_max;
    logic        exp_zero;
    logic        frac_zero;
    logic [5:0]  lz;
    logic        lz_found;
    logic [51:0] norm_frac;
    logic [10:0] norm_exp;

    assign sgn       = in_bits[63];
    assign exp_f     = in_bits[62:52];
    assign frac      = in_bits[51:0];
    assign exp_max   = (exp_f == 11'h7FF);
    assign exp_zero  = (exp_f == 11'h000);
    assign frac_zero = (frac == 52'd0);

    always_comb begin
        lz       = 6'd0;
        lz_found = 1'b0;
        for (int i = 51; i >= 0; i--) begin
            if (!lz_found && frac[i]) begin
                lz       = 6'(51 - i);
                lz_found = 1'b1;
            end
        end
    end

    // Shifting out the leading one leaves the hidden bit implicit; the exponent
    // then encodes f * 2^-1074 * 2^54 exactly.
    assign norm_frac = frac << (lz + 6'd1);
    assign norm_exp  = 11'(RSQRT_SUB_PRESCALE) - {5'd0, lz};

    always_comb begin
        x_bits = RSQRT_ONE;
        cls    = CLS_NORMAL;
        bypass = 64'd0;
        scale  = 1'b0;
        if (exp_max && !frac_zero) begin
            cls    = CLS_NAN;
            bypass = in_bits | 64'h0008_0000_0000_0000;
        end else if (sgn && !(exp_zero && frac_zero)) begin
            cls    = CLS_NEG;
            bypass = RSQRT_QNAN;
        end else if (exp_max) begin
            cls    = CLS_INF;
        end else if (exp_zero && frac_zero) begin
            cls    = CLS_ZERO;
            bypass = {sgn, 11'h7FF, 52'd0};
        end else if (exp_zero) begin
            cls    = CLS_SUBNORM;
            x_bits = {1'b0, norm_exp, norm_frac};
            scale  = 1'b1;
        end else begin
            x_bits = in_bits;
        end
    end

endmodule

// File: rtl/rsqrt_operand_stage.sv
// rtl/rsqrt_operand_stage.sv - operand classifier feeding an in-order FIFO toward the rsqrt compute stage
module rsqrt_operand_stage
    import rsqrt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_bits,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_x_bits,
    output logic [2:0]       out_class,
    output logic [63:0]      out_bypass_bits,
    output logic             out_scale,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      cnt_special
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rsqrt_entry_t      mem     [DEPTH];
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;
    rsqrt_entry_t      cls_entry;
    rsqrt_entry_t      head;

    rsqrt_classify u_classify (
        .in_bits (in_bits),
        .x_bits  (cls_entry.x_bits),
        .cls     (cls_entry.cls),
        .bypass  (cls_entry.bypass),
        .scale   (cls_entry.scale)
    );

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            // in_ready is only 1 below DEPTH, so a full FIFO never sees push+pop.
            in_ready <= (count_next < CW'(DEPTH));
        end
    end

    // Storage is cleared so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]     <= '0;
                tag_mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr]     <= cls_entry;
            tag_mem[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_special <= 16'd0;
        end else if (push && cls_entry.cls != CLS_NORMAL && cnt_special != 16'hFFFF) begin
            cnt_special <= cnt_special + 16'd1;
        end
    end

    assign head            = mem[rd_ptr];
    assign out_valid       = (count != '0);
    assign out_x_bits      = head.x_bits;
    assign out_class       = head.cls;
    assign out_bypass_bits = head.bypass;
    assign out_scale       = head.scale;
    assign out_tag         = tag_mem[rd_ptr];

endmodule

// File: tb/tb_rsqrt_operand_stage.sv
// tb/tb_rsqrt_operand_stage.sv - scoreboard bench for rsqrt_operand_stage
module tb_rsqrt_operand_stage;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [63:0]      x;
        logic [2:0]       cls;
        logic [63:0]      byp;
        logic             scale;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_bits = 64'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_x_bits;
    logic [2:0]       out_class;
    logic [63:0]      out_bypass_bits;
    logic             out_scale;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      cnt_special;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    rsqrt_operand_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_bits         (in_bits),
        .in_tag          (in_tag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_x_bits      (out_x_bits),
        .out_class       (out_class),
        .out_bypass_bits (out_bypass_bits),
        .out_scale       (out_scale),
        .out_tag         (out_tag),
        .cnt_special     (cnt_special)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] b, input logic [TAG_W-1:0] t);
        exp_t        r;
        logic [52:0] m;
        int          k;
        r.x = 64'h3FF0_0000_0000_0000; r.byp = 64'd0; r.scale = 1'b0; r.tag = t;
        if (b[62:52] == 11'h7FF && b[51:0] != 52'd0) begin
            r.cls = 3'd5; r.byp = {b[63:52], 1'b1, b[50:0]};
        end else if (b[63] && b[62:0] != 63'd0) begin
            r.cls = 3'd4; r.byp = 64'h7FF8_0000_0000_0000;
        end else if (b[62:52] == 11'h7FF) begin
            r.cls = 3'd3;
        end else if (b[62:0] == 63'd0) begin
            r.cls = 3'd2; r.byp = {b[63], 63'h7FF0_0000_0000_0000};
        end else if (b[62:52] == 11'd0) begin
            m = {1'b0, b[51:0]};
            k = 0;
            while (!m[52]) begin m = m << 1; k++; end
            r.cls = 3'd1; r.scale = 1'b1;
            r.x = {1'b0, 11'(55 - k), m[51:0]};
        end else begin
            r.cls = 3'd0; r.x = b;
        end
        return r;
    endfunction

    // Inputs change 1 time unit after a rising edge; handshakes are judged at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got tag %0h with empty scoreboard", out_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({out_x_bits, out_class, out_bypass_bits, out_scale, out_tag} !== e) begin
                    errors++;
                    $display("FAIL pop_payload: got x=%h cls=%0d byp=%h sc=%0b tag=%0h want x=%h cls=%0d byp=%h sc=%0b tag=%0h",
                             out_x_bits, out_class, out_bypass_bits, out_scale, out_tag,
                             e.x, e.cls, e.byp, e.scale, e.tag);
                end
            end
        end
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_bits, in_tag));
    end

    task automatic push_one(input logic [63:0] b, input logic [TAG_W-1:0] t);
        bit ok = 1'b0;
        in_valid = 1'b1; in_bits = b; in_tag = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL push_timeout: in_ready stayed %0b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [63:0] x, input logic [2:0] c,
                              input logic [63:0] byp, input logic sc);
        checks++;
        if (out_valid !== 1'b1 || out_x_bits !== x || out_class !== c ||
            out_bypass_bits !== byp || out_scale !== sc) begin
            errors++;
            $display("FAIL %s: got v=%0b x=%h cls=%0d byp=%h sc=%0b want v=1 x=%h cls=%0d byp=%h sc=%0b",
                     name, out_valid, out_x_bits, out_class, out_bypass_bits, out_scale, x, c, byp, sc);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (out_valid || exp_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: scoreboard left %0d out_valid=%0b want 0 and 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_x_bits !== 64'd0 || out_class !== 3'd0 ||
            out_bypass_bits !== 64'd0 || out_scale !== 1'b0 || out_tag !== '0 || cnt_special !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b v=%0b x=%h cls=%0d byp=%h sc=%0b tag=%0h cnt=%0h want all 0",
                     in_ready, out_valid, out_x_bits, out_class, out_bypass_bits, out_scale, out_tag, cnt_special);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge: got %0b want 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_normal();
        logic [15:0] c0;
        out_ready = 1'b1;
        c0 = cnt_special;
        push_one(64'h4010_0000_0000_0000, 4'd3);
        check_head("normal_4p0", 64'h4010_0000_0000_0000, 3'd0, 64'd0, 1'b0);
        checks++;
        if (out_tag !== 4'd3 || cnt_special !== c0) begin
            errors++;
            $display("FAIL normal_tag_cnt: tag=%0h cnt=%0h want tag=3 cnt=%0h", out_tag, cnt_special, c0);
        end
        drain();
    endtask

    task automatic test_subnormal();
        out_ready = 1'b1;
        push_one(64'h0000_0000_0000_0001, 4'd1);
        check_head("subnorm_min", 64'h0030_0000_0000_0000, 3'd1, 64'd0, 1'b1);
        push_one(64'h000F_FFFF_FFFF_FFFF, 4'd2);
        check_head("subnorm_max", 64'h036F_FFFF_FFFF_FFFE, 3'd1, 64'd0, 1'b1);
        push_one(64'h0000_0400_0000_0123, 4'd4);
        drain();
    endtask

    task automatic test_special();
        logic [15:0] c0;
        out_ready = 1'b1;
        push_one(64'h8000_0000_0000_0000, 4'd5);
        check_head("neg_zero", 64'h3FF0_0000_0000_0000, 3'd2, 64'hFFF0_0000_0000_0000, 1'b0);
        push_one(64'h7FF0_0000_0000_0000, 4'd6);
        check_head("pos_inf", 64'h3FF0_0000_0000_0000, 3'd3, 64'd0, 1'b0);
        c0 = cnt_special;
        push_one(64'hC000_0000_0000_0000, 4'd7);
        check_head("neg_two", 64'h3FF0_0000_0000_0000, 3'd4, 64'h7FF8_0000_0000_0000, 1'b0);
        push_one(64'h7FF0_0000_0000_0001, 4'd8);
        check_head("snan", 64'h3FF0_0000_0000_0000, 3'd5, 64'h7FF8_0000_0000_0001, 1'b0);
        checks++;
        if (cnt_special !== c0 + 16'd2) begin
            errors++; $display("FAIL cnt_special_plus2: got %0h want %0h", cnt_special, c0 + 16'd2);
        end
        push_one(64'hFFF0_0000_0000_0000, 4'd9);
        push_one(64'h800F_0000_0000_0000, 4'd10);
        push_one(64'h0000_0000_0000_0000, 4'd11);
        drain();
    endtask

    task automatic test_backpressure();
        logic [63:0] hx;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            push_one(64'h4000_0000_0000_0000 + 64'(i) * 64'h1_0000_1111, 4'(8 + i));
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd8) begin
            errors++;
            $display("FAIL full_state: rdy=%0b v=%0b tag=%0h want rdy=0 v=1 tag=8", in_ready, out_valid, out_tag);
        end
        hx = out_x_bits;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_tag !== 4'd8 || out_x_bits !== hx) begin
            errors++;
            $display("FAIL head_stable: tag=%0h x=%h want tag=8 x=%h", out_tag, out_x_bits, hx);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_pop: got %0b want 1", in_ready);
        end
        in_valid = 1'b1; in_bits = 64'h4030_0000_0000_0000; in_tag = 4'd12; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_tag !== 4'd10) begin
            errors++;
            $display("FAIL push_pop_occupancy: rdy=%0b tag=%0h want rdy=1 tag=a", in_ready, out_tag);
        end
        push_one(64'h0000_0000_0000_0100, 4'd13);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL refill_full: rdy=%0b want 0", in_ready);
        end
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        in_valid = 1'b1; in_bits = 64'hC000_0000_0000_0000; in_tag = 4'd1;
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (cnt_special !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_saturate: got %0h want ffff", cnt_special);
        end
        push_one(64'h7FF0_0000_0000_0000, 4'd2);
        checks++;
        if (cnt_special !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_hold: got %0h want ffff", cnt_special);
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push_one(64'h4010_0000_0000_0000, 4'd1);
        push_one(64'h8000_0000_0000_0000, 4'd2);
        push_one(64'hC000_0000_0000_0000, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || cnt_special !== 16'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: v=%0b cnt=%0h rdy=%0b want 0 0 0", out_valid, cnt_special, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_release: rdy=%0b v=%0b want 0 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_one(64'h3FF8_0000_0000_0000, 4'd6);
        check_head("push_after_reset", 64'h3FF8_0000_0000_0000, 3'd0, 64'd0, 1'b0);
        checks++;
        if (out_tag !== 4'd6) begin
            errors++; $display("FAIL tag_after_reset: got %0h want 6", out_tag);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_subnormal();
        test_special();
        test_backpressure();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
